// File: rtl/shifter_input_conditioner_amisha.sv
// ---------------------------------------------------------------------------
// shifter_input_conditioner_amisha
//
// Upstream stage of the barrel-shifter test datapath. Turns raw, bouncy,
// asynchronous board inputs into clean synchronous vectors for the shifter
// test block:
//   - every raw bit passes through a two-flop synchronizer (s1 -> s2)
//   - each of the 3 buttons has its own ZERO/WAIT1/ONE/WAIT0 debounce FSM
//   - the 8 slide switches are debounced as one group, so a new switch
//     vector only appears once the whole bus has been stable for the window
//   - upd_amisha pulses for one cycle in the first cycle a new conditioned
//     value is visible on btn_amisha or sw_amisha
//
// Parameters:
//   DB_TICKS  consecutive stable cycles required before an output changes
//             (legal range 1 .. 2^CNT_W-1)
//   CNT_W     width of the debounce counters
//
// Ports:
//   clk_amisha      in   1  system clock, rising edge
//   rst_n_amisha    in   1  asynchronous active-low reset
//   btn_raw_amisha  in   3  raw push-button levels (asynchronous)
//   sw_raw_amisha   in   8  raw slide-switch levels (asynchronous)
//   btn_amisha      out  3  debounced button levels
//   sw_amisha       out  8  debounced switch vector
//   upd_amisha      out  1  one-cycle pulse on any conditioned-output change
// ---------------------------------------------------------------------------
module shifter_input_conditioner_amisha #(
  parameter int DB_TICKS = 1000000,
  parameter int CNT_W    = 20
) (
  input  logic       clk_amisha,
  input  logic       rst_n_amisha,
  input  logic [2:0] btn_raw_amisha,
  input  logic [7:0] sw_raw_amisha,
  output logic [2:0] btn_amisha,
  output logic [7:0] sw_amisha,
  output logic       upd_amisha
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } btn_state_e;

  // Counter load value: the window is counted down to zero, and the output
  // changes on the edge that finds the counter already at zero.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DB_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Synchronizer stages
  logic [2:0]       btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [7:0]       sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;

  // Per-button debounce FSMs
  btn_state_e       btn_state_q [3];
  btn_state_e       btn_state_d [3];
  logic [CNT_W-1:0] btn_cnt_q [3];
  logic [CNT_W-1:0] btn_cnt_d [3];
  logic [2:0]       btn_q, btn_d;

  // Switch group debounce
  logic [7:0]       cand_q, cand_d;
  logic [7:0]       sw_q, sw_d;
  logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;

  // Update strobe
  logic             upd_q, upd_d;

  // Two-flop synchronizers: only the second stage is ever looked at.
  always_comb begin
    btn_s1_d = btn_raw_amisha;
    btn_s2_d = btn_s1_q;
    sw_s1_d  = sw_raw_amisha;
    sw_s2_d  = sw_s1_q;
  end

  // Button FSM next-state logic. A bounce back to the old level during a
  // WAIT state drops straight back to the settled state, so the window
  // restarts from scratch on the next change. Counters are only reloaded or
  // decremented while nonzero, so they never wrap.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      btn_state_d[i] = btn_state_q[i];
      btn_cnt_d[i]   = btn_cnt_q[i];
      unique case (btn_state_q[i])
        ZERO: begin
          if (btn_s2_q[i]) begin
            btn_state_d[i] = WAIT1;
            btn_cnt_d[i]   = RELOAD;
          end
        end
        WAIT1: begin
          if (!btn_s2_q[i]) begin
            btn_state_d[i] = ZERO;
          end else if (btn_cnt_q[i] == '0) begin
            btn_state_d[i] = ONE;
          end else begin
            btn_cnt_d[i] = btn_cnt_q[i] - CNT_ONE;
          end
        end
        ONE: begin
          if (!btn_s2_q[i]) begin
            btn_state_d[i] = WAIT0;
            btn_cnt_d[i]   = RELOAD;
          end
        end
        WAIT0: begin
          if (btn_s2_q[i]) begin
            btn_state_d[i] = ONE;
          end else if (btn_cnt_q[i] == '0) begin
            btn_state_d[i] = ZERO;
          end else begin
            btn_cnt_d[i] = btn_cnt_q[i] - CNT_ONE;
          end
        end
      endcase
    end
  end

  // Button FSM outputs: decoded from the next state and registered, so the
  // level driven to the shifter comes straight from a flop.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      btn_d[i] = (btn_state_d[i] == ONE) || (btn_state_d[i] == WAIT0);
    end
  end

  // Switch group debounce. Any bit differing from the candidate restarts the
  // window for the whole bus; the candidate is only committed once it has
  // survived a full window, so a partially settled vector is never shown.
  always_comb begin
    cand_d   = cand_q;
    sw_cnt_d = sw_cnt_q;
    sw_d     = sw_q;
    if (sw_s2_q != cand_q) begin
      cand_d   = sw_s2_q;
      sw_cnt_d = RELOAD;
    end else if (cand_q != sw_q) begin
      if (sw_cnt_q == '0) begin
        sw_d = cand_q;
      end else begin
        sw_cnt_d = sw_cnt_q - CNT_ONE;
      end
    end
  end

  // One strobe covers button and switch changes landing on the same edge.
  always_comb begin
    upd_d = (btn_d != btn_q) || (sw_d != sw_q);
  end

  // All state registers. Reset aborts any debounce in flight.
  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        btn_state_q[i] <= ZERO;
        btn_cnt_q[i]   <= '0;
      end
      btn_q    <= '0;
      cand_q   <= '0;
      sw_q     <= '0;
      sw_cnt_q <= '0;
      upd_q    <= 1'b0;
    end else begin
      btn_s1_q <= btn_s1_d;
      btn_s2_q <= btn_s2_d;
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
      for (int i = 0; i < 3; i++) begin
        btn_state_q[i] <= btn_state_d[i];
        btn_cnt_q[i]   <= btn_cnt_d[i];
      end
      btn_q    <= btn_d;
      cand_q   <= cand_d;
      sw_q     <= sw_d;
      sw_cnt_q <= sw_cnt_d;
      upd_q    <= upd_d;
    end
  end

  assign btn_amisha = btn_q;
  assign sw_amisha  = sw_q;
  assign upd_amisha = upd_q;

endmodule

// File: doc/shifter_input_conditioner_amisha.md
Name: shifter_input_conditioner_amisha

Overview:
- Upstream stage of the barrel-shifter test datapath.
- Conditions raw board buttons (3) and slide switches (8) into clean, synchronous btn_amisha / sw_amisha vectors that directly drive the shifter test block's shift-control and data inputs.
- Per-input two-flop synchronization, per-button debounce FSM, and group debounce of the switch bus.
- Emits a one-cycle update strobe whenever the conditioned outputs change.

Parameters:
- DB_TICKS, 1000000, number of consecutive stable clock cycles required before a debounced output changes (10 ms at 100 MHz); legal range 1 to 2^CNT_W-1.
- CNT_W, 20, width of the debounce counters.

Ports:
- clk_amisha  input  1  system clock, all logic on rising edge.
- rst_n_amisha  input  1  asynchronous active-low reset.
- btn_raw_amisha  input  3  raw push-button levels, asynchronous to clk_amisha.
- sw_raw_amisha  input  8  raw slide-switch levels, asynchronous to clk_amisha.
- btn_amisha  output  3  debounced button levels; feed the shifter test block's btn_amisha.
- sw_amisha  output  8  debounced switch vector; feed the shifter test block's sw_amisha.
- upd_amisha  output  1  one-cycle pulse, high in the first cycle a new btn_amisha/sw_amisha value is visible.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - While rst_n_amisha=0: btn_amisha=0, sw_amisha=0, upd_amisha=0. All sync flops, candidate register and counters are 0; all button FSMs are in ZERO.
  - Reset asserted mid-debounce aborts the debounce immediately; no output change follows deassertion unless the input is again stable for the full window.
- Synchronizer: two flops per raw bit (s1, s2). Only s2 is used downstream.
- Per-button FSM (3 independent instances), states ZERO, WAIT1, ONE, WAIT0:
  - ZERO: s2=1 -> WAIT1, cnt<=DB_TICKS-1.
  - WAIT1: s2=0 -> ZERO; else cnt==0 -> ONE; else cnt<=cnt-1.
  - ONE: s2=0 -> WAIT0, cnt<=DB_TICKS-1.
  - WAIT0: s2=1 -> ONE; else cnt==0 -> ZERO; else cnt<=cnt-1.
  - btn_amisha[i] is a registered output: 1 in ONE and WAIT0, 0 in ZERO and WAIT1.
- Switch group debounce (single counter for all 8 bits, candidate register cand):
  - Each edge, if s2 != cand: cand<=s2, cnt<=DB_TICKS-1.
  - Else if cand != sw_amisha: cnt==0 -> sw_amisha<=cand; else cnt<=cnt-1.
  - Any bit change restarts the window for the whole bus, so sw_amisha never shows a partially settled vector.
- Latency: with the input held constant after a change, the output updates on the (DB_TICKS+3)th rising edge after the edge that first samples the change into s1. Pulses shorter than DB_TICKS cycles at s2 never reach the outputs.
- upd_amisha:
  - Registered; set on the same edge that any btn_amisha or sw_amisha bit changes, cleared on the next edge.
  - Simultaneous button and switch changes on one edge give a single one-cycle pulse.
  - Changes on consecutive edges keep upd_amisha high on both cycles.
- Counters never wrap: cnt is only loaded or decremented while nonzero.
- DB_TICKS=1 is legal: output updates on edge 4.

Test Plan (DB_TICKS=4):
- Reset hold: rst_n_amisha=0 with raw btn=7, sw=255 -> btn_amisha=0, sw_amisha=0, upd_amisha=0; after release with inputs held, outputs become 7 and 255 on edge 7 and upd_amisha pulses once.
- Clean step: btn_raw=3, sw_raw=5 from 0 -> btn_amisha=3, sw_amisha=5 exactly 7 edges after the s1 capture edge; upd_amisha high for exactly 1 cycle.
- Bounce rejection: sw_raw toggles 26/0 every 2 cycles for 20 cycles, then holds 26 -> sw_amisha never shows intermediate values and reaches 26 on the 7th edge after the final toggle.
- Glitch: btn_raw[0] high for 3 cycles only -> btn_amisha stays 0 and upd_amisha stays 0.
- Sequence: drive (btn,sw) = (2,26), (0,37), (1,12), each held 20 cycles -> outputs track each pair with latency 7 and exactly one upd_amisha pulse per pair.
- Reset mid-window: sw_raw 0->37, assert rst_n_amisha=0 at edge 5 for 2 cycles -> outputs stay 0 throughout reset and update to 37 only 7 edges after release.
